// File: rtl/nes_button_events.sv
// Button level -> press/repeat/release event stream with a small show-ahead FIFO.
// Define NES_RELEASE_EVENTS_EN to generate release events; otherwise falling edges are ignored.
module nes_button_events #(
    parameter int TICK_DIV      = 50000,
    parameter int REPEAT_DELAY  = 400,
    parameter int REPEAT_PERIOD = 100,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       select,
    input  logic       start,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       evt_ready,
    input  logic       ovf_clear,
    output logic       evt_valid,
    output logic [4:0] evt_data,
    output logic [7:0] held,
    output logic       overflow
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [CW-1:0] FIFO_FULL   = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic       is_rel;
        logic       is_rep;
        logic [2:0] idx;
    } evt_t;

    logic [7:0] w_buttons;
    logic [7:0] r_held;
    logic [7:0] r_held_d;
    logic [7:0] w_rise;
    logic [3:0] w_fall_dir;

    assign w_buttons  = {right, left, down, up, start, select, B, A};
    assign w_rise     = r_held & ~r_held_d;
    assign w_fall_dir = r_held_d[7:4] & ~r_held[7:4];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_held   <= '0;
            r_held_d <= '0;
        end else begin
            r_held   <= w_buttons;
            r_held_d <= r_held;
        end
    end

    logic [PW-1:0] r_presc;
    logic          w_tick;

    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 1'b1;
    end

    // Direction buttons: count ticks while held, repeat at REPEAT_DELAY then every REPEAT_PERIOD.
    logic [HW-1:0] r_hold_cnt [4];
    logic [3:0]    w_rep_set;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_rep_set[i] = w_tick && r_held[4+i] && !w_rise[4+i] && (r_hold_cnt[i] == HOLD_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_hold_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_rise[4+i] || !r_held[4+i]) r_hold_cnt[i] <= '0;
                else if (w_rep_set[i])           r_hold_cnt[i] <= HOLD_RELOAD;
                else if (w_tick)                 r_hold_cnt[i] <= r_hold_cnt[i] + 1'b1;
            end
        end
    end

    logic [7:0]    r_press_pend;
    logic [3:0]    r_rep_pend;
    logic [7:0]    w_rel_pend;
    logic [3:0]    w_rep_cand;
    logic [CW-1:0] r_count;
    logic          w_can_push;
    logic          w_push;
    evt_t          w_push_evt;
    logic          w_prs_hit, w_rep_hit, w_rel_hit;
    logic [2:0]    w_prs_idx, w_rep_idx, w_rel_idx;

    // A repeat being cancelled by a release this cycle is never emitted.
    assign w_rep_cand = r_rep_pend & ~w_fall_dir;
    assign w_can_push = (r_count < FIFO_FULL);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_prs_hit = 1'b0;
        w_prs_idx = '0;
        w_rep_hit = 1'b0;
        w_rep_idx = '0;
        w_rel_hit = 1'b0;
        w_rel_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (r_press_pend[i]) begin
                w_prs_hit = 1'b1;
                w_prs_idx = 3'(i);
            end
            if (w_rel_pend[i]) begin
                w_rel_hit = 1'b1;
                w_rel_idx = 3'(i);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            if (w_rep_cand[i]) begin
                w_rep_hit = 1'b1;
                w_rep_idx = 3'(i + 4);
            end
        end

        w_push     = 1'b0;
        w_push_evt = '0;
        if (w_can_push) begin
            if (w_prs_hit) begin
                w_push     = 1'b1;
                w_push_evt = '{is_rel: 1'b0, is_rep: 1'b0, idx: w_prs_idx};
            end else if (w_rep_hit) begin
                w_push     = 1'b1;
                w_push_evt = '{is_rel: 1'b0, is_rep: 1'b1, idx: w_rep_idx};
            end else if (w_rel_hit) begin
                w_push     = 1'b1;
                w_push_evt = '{is_rel: 1'b1, is_rep: 1'b0, idx: w_rel_idx};
            end
        end
    end

    logic [7:0] w_sel_onehot;
    logic [7:0] w_clr_press;
    logic [3:0] w_clr_rep;
    logic [7:0] w_coal_press;
    logic [3:0] w_coal_rep;
    logic [7:0] w_coal_rel;

    assign w_sel_onehot = 8'b1 << w_push_evt.idx;
    assign w_clr_press  = (w_push && !w_push_evt.is_rel && !w_push_evt.is_rep) ? w_sel_onehot : '0;
    assign w_clr_rep    = (w_push && w_push_evt.is_rep) ? w_sel_onehot[7:4] : '0;
    assign w_coal_press = w_rise & r_press_pend & ~w_clr_press;
    assign w_coal_rep   = w_rep_set & r_rep_pend & ~w_clr_rep;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_press_pend <= '0;
            r_rep_pend   <= '0;
        end else begin
            r_press_pend <= (r_press_pend & ~w_clr_press) | w_rise;
            r_rep_pend   <= ((r_rep_pend & ~w_clr_rep) | w_rep_set) & ~w_fall_dir;
        end
    end

`ifdef NES_RELEASE_EVENTS_EN
    logic [7:0] r_rel_pend;
    logic [7:0] w_fall;
    logic [7:0] w_clr_rel;

    assign w_fall     = r_held_d & ~r_held;
    assign w_clr_rel  = (w_push && w_push_evt.is_rel) ? w_sel_onehot : '0;
    assign w_rel_pend = r_rel_pend;
    assign w_coal_rel = w_fall & r_rel_pend & ~w_clr_rel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rel_pend <= '0;
        else       r_rel_pend <= (r_rel_pend & ~w_clr_rel) | w_fall;
    end
`else
    assign w_rel_pend = '0;
    assign w_coal_rel = '0;
`endif

    // A coalesce in the same cycle as ovf_clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                       overflow <= 1'b0;
        else if (|{w_coal_press, w_coal_rep, w_coal_rel}) overflow <= 1'b1;
        else if (ovf_clear)                              overflow <= 1'b0;
    end

    evt_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic          w_pop;

    assign evt_valid = (r_count != '0);
    assign w_pop     = evt_valid && evt_ready;
    assign evt_data  = r_mem[r_rd_ptr];
    assign held      = r_held;

    // NOTE: the storage is tiny, so it is reset to give evt_data a defined value out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_evt;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_nes_button_events.sv
// Directed bench for nes_button_events; release expectations follow NES_RELEASE_EVENTS_EN.
module tb_nes_button_events;

    localparam int TICK_DIV      = 4;
    localparam int REPEAT_DELAY  = 3;
    localparam int REPEAT_PERIOD = 2;
    localparam int FIFO_DEPTH    = 4;

`ifdef NES_RELEASE_EVENTS_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       A, B, select, start, up, down, left, right;
    logic       evt_ready;
    logic       ovf_clear;
    logic       evt_valid;
    logic [4:0] evt_data;
    logic [7:0] held;
    logic       overflow;

    int n_compared   = 0;
    int n_mismatched = 0;

    nes_button_events #(
        .TICK_DIV      (TICK_DIV),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .select    (select),
        .start     (start),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .evt_ready (evt_ready),
        .ovf_clear (ovf_clear),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .held      (held),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_buttons(input logic [7:0] b);
        {right, left, down, up, start, select, B, A} = b;
    endtask

    task automatic expect_evt(input string tag, input logic [4:0] d);
        check(tag, 32'({evt_valid, evt_data}), 32'({1'b1, d}));
    endtask

    task automatic expect_idle(input string tag);
        check(tag, 32'(evt_valid), 32'd0);
    endtask

    task automatic expect_rel(input string tag, input logic [2:0] idx);
        logic [5:0] got;
        logic [5:0] exp;
        got = {evt_valid, evt_valid ? evt_data : 5'h00};
        exp = REL_EN ? {1'b1, 2'b10, idx} : 6'h00;
        check(tag, 32'(got), 32'(exp));
    endtask

    task automatic count_events(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (evt_valid) cnt++;
        end
    endtask

    int         t_evt [$];
    logic [4:0] d_evt [$];
    logic [4:0] drain_exp [9];

    initial begin
        int cnt;
        int gap;

        reset     = 1'b1;
        evt_ready = 1'b0;
        ovf_clear = 1'b0;
        set_buttons(8'h00);
        step(3);
        check("rst_valid",    32'(evt_valid), 32'd0);
        check("rst_data",     32'(evt_data),  32'd0);
        check("rst_held",     32'(held),      32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        reset = 1'b0;
        step(2);

        // Single press / release of A.
        evt_ready = 1'b1;
        set_buttons(8'h01);
        step();
        check("t1_held_rise", 32'(held), 32'h01);
        expect_idle("t1_lat1");
        step();
        expect_idle("t1_lat2");
        step();
        expect_evt("t1_press", 5'h00);
        step();
        expect_idle("t1_popped");
        count_events(16, cnt);
        check("t1_no_extra", 32'(cnt), 32'd0);
        set_buttons(8'h00);
        step();
        check("t1_held_fall", 32'(held), 32'h00);
        step(2);
        expect_rel("t1_release", 3'd0);
        step();
        expect_idle("t1_after_rel");

        // B, start and up pressed together.
        set_buttons(8'h1A);
        step(3);
        expect_evt("t2_b", 5'h01);
        step();
        expect_evt("t2_start", 5'h03);
        step();
        expect_evt("t2_up", 5'h04);
        step();
        expect_idle("t2_idle");
        set_buttons(8'h00);
        step(3);
        expect_rel("t2_rel_b", 3'd1);
        step();
        expect_rel("t2_rel_start", 3'd3);
        step();
        expect_rel("t2_rel_up", 3'd4);
        step();
        expect_idle("t2_idle2");

        // Auto-repeat on right held for 40 cycles.
        set_buttons(8'h80);
        for (int k = 1; k <= 40; k++) begin
            step();
            if (evt_valid) begin
                t_evt.push_back(k);
                d_evt.push_back(evt_data);
            end
        end
        check("t3_count", 32'(t_evt.size()), 32'd5);
        if (t_evt.size() >= 2) begin
            check("t3_press_cycle", 32'(t_evt[0]), 32'd3);
            check("t3_press_data",  32'(d_evt[0]), 32'h07);
            gap = t_evt[1] - t_evt[0];
            check("t3_first_gap_in_9_12", 32'(gap >= 9 && gap <= 12), 32'd1);
            for (int i = 1; i < t_evt.size(); i++) begin
                check("t3_repeat_data", 32'(d_evt[i]), 32'h0F);
                if (i >= 2) check("t3_period_gap", 32'(t_evt[i] - t_evt[i-1]), 32'd8);
            end
        end
        set_buttons(8'h00);
        step(3);
        expect_rel("t3_release", 3'd7);
        count_events(20, cnt);
        check("t3_no_repeat_after_rel", 32'(cnt), 32'd0);

        // Backpressure and overflow.
        evt_ready = 1'b0;
        set_buttons(8'hFF);
        step(6);
        expect_evt("t4_head", 5'h00);
        check("t4_ovf_clear", 32'(overflow), 32'd0);
        set_buttons(8'hFE);
        step();
        set_buttons(8'hFF);
        step();
        set_buttons(8'hFE);
        step();
        set_buttons(8'hFF);
        step(3);
        check("t4_ovf_set", 32'(overflow), 32'd1);
        drain_exp = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h00, 5'h04, 5'h05, 5'h06, 5'h07};
        evt_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            expect_evt($sformatf("t4_drain%0d", i), drain_exp[i]);
            step();
        end
        set_buttons(8'h00);
        step(40);
        expect_idle("t4_drained");
        check("t4_ovf_sticky", 32'(overflow), 32'd1);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        check("t4_ovf_cleared", 32'(overflow), 32'd0);

        // Reset with three events queued; left stays held through reset.
        evt_ready = 1'b0;
        set_buttons(8'h07);
        step(5);
        expect_evt("t5_queued_head", 5'h00);
        set_buttons(8'h47);
        step();
        reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(evt_valid), 32'd0);
        check("t5_rst_held",  32'(held),      32'd0);
        evt_ready = 1'b1;
        set_buttons(8'h40);
        step(2);
        reset = 1'b0;
        step();
        check("t5_held_left", 32'(held), 32'h40);
        step(2);
        expect_evt("t5_left_press", 5'h06);
        step();
        expect_idle("t5_single");
        set_buttons(8'h00);
        step(3);
        expect_rel("t5_left_rel", 3'd6);
        step();
        expect_idle("t5_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/nes_button_events.md
# nes_button_events

Converts the eight registered button levels produced by `nes_controller` into a stream of discrete button events for the game logic. Detects press and release edges and generates auto-repeat events for held direction buttons. Queues events in a small show-ahead FIFO with a valid/ready handshake. Sits directly downstream of `nes_controller` and upstream of the game state machine.

## Interface
- `TICK_DIV`, 50000, clk cycles per repeat tick (1 ms at 50 MHz); ≥2
- `REPEAT_DELAY`, 400, ticks from press to first repeat; ≥1
- `REPEAT_PERIOD`, 100, ticks between subsequent repeats; ≥1, ≤ REPEAT_DELAY
- `FIFO_DEPTH`, 4, event FIFO entries; power of two, ≥2
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `A`, `B`, `select`, `start`, `up`, `down`, `left`, `right`  in  1 each  button levels from `nes_controller`; 1 = pressed
- `evt_ready`  in  1  consumer accepts the head event this cycle
- `ovf_clear`  in  1  clears `overflow`
- `evt_valid`  out  1  FIFO non-empty; `evt_data` valid
- `evt_data`  out  5  [4]=release, [3]=repeat, [2:0]=button index (A=0, B=1, select=2, start=3, up=4, down=5, left=6, right=7)
- `held`  out  8  registered button levels, index order as above
- `overflow`  out  1  sticky; an event was coalesced and lost

## Operation
- Reset values: `evt_valid`=0, `evt_data`=0, `held`=0, `overflow`=0, FIFO empty, pending bits 0, prescaler 0, hold counters 0.
- Inputs are registered into `held` every cycle. Edge detection compares the new sample with `held`. Because `held` resets to 0, buttons held across reset deassertion produce a press event.
- Each button has press-pending and release-pending bits. Buttons 4–7 also have a repeat-pending bit.
- Rising edge sets press-pending. Falling edge sets release-pending.
- Setting a pending bit that is already set coalesces the event and sets `overflow`.
- Arbiter: at most one FIFO write per cycle, only when the FIFO count is below FIFO_DEPTH. Selection order is lowest-index press-pending, then lowest-index repeat-pending, then lowest-index release-pending. The written bit clears.
- Prescaler counts 0..TICK_DIV-1 and runs freely. `tick` pulses when the count is TICK_DIV-1.
- Direction hold counter, per button 4–7:
  - cleared on press and whenever the button is not held;
  - on each `tick` while held, increments;
  - on reaching REPEAT_DELAY, sets repeat-pending and reloads to REPEAT_DELAY-REPEAT_PERIOD.
- A release clears any repeat-pending bit for that button without emitting the repeat.
- FIFO pop occurs when `evt_valid && evt_ready`. `evt_data` always shows the head entry (show-ahead).
- `ovf_clear` clears `overflow`. If a coalesce occurs in the same cycle, set wins.

## Timing
- Input change sampled at edge E0: `held` updates at E0, pending is set at E0+1, FIFO write at E0+2, `evt_valid`=1 after E0+2. Latency is 2 cycles from `held` to `evt_valid`.
- Pop at edge P: the next entry appears after P. `evt_valid` drops after P if the FIFO is empty.
- FIFO full with a pop in the same cycle: the push is deferred one cycle (no simultaneous push at full). Pending bits hold meanwhile.
- First repeat occurs REPEAT_DELAY ticks after press. Jitter is up to one tick (free-running prescaler). Later repeats are exactly REPEAT_PERIOD ticks apart.
- Reset asserted mid-operation: all state returns to reset values immediately. Queued and pending events are discarded.

## Configuration
- `NES_RELEASE_EVENTS_EN` defined: release events are generated as described; `evt_data[4]` can be 1.
- Not defined: no release-pending logic, falling edges are ignored, and `evt_data[4]` is constant 0. `held` and repeat cancellation on release are unchanged.

## Test plan
Bench parameters: TICK_DIV=4, REPEAT_DELAY=3, REPEAT_PERIOD=2, FIFO_DEPTH=4, `NES_RELEASE_EVENTS_EN` defined.

- Single press/release: `evt_ready`=1, `A` 0→1, held 20 cycles, then 1→0 -> `evt_data`=0x00 with `evt_valid` 2 cycles after `held[0]` rises; then 0x10 after release; no other events.
- Simultaneous press: `B`, `start`, and `up` rise in the same cycle with `evt_ready`=1 -> events 0x01, 0x03, 0x04 on consecutive cycles.
- Auto-repeat: `right` held 40 cycles -> press 0x07, then repeat events 0x0F. The first repeat arrives 9–12 cycles after press; later repeats are 8 cycles apart. Release gives 0x17 and no further repeats.
- Backpressure/overflow: `evt_ready`=0 and all 8 buttons pressed -> 4 events (0x00–0x03) queued, pending held, `overflow`=0. Toggling `A` off and on twice more sets `overflow`=1. `evt_ready`=1 then drains events in priority order. `ovf_clear` returns `overflow` to 0.
- Reset mid-stream: assert `reset` with 3 events queued -> `evt_valid`=0, `held`=0 immediately. On deassert with `left` still high, the single event 0x06 appears.
- Macro undefined: repeat test 1 -> only 0x00 is emitted; `held[0]` still follows `A`.
